// File: rtl/sram_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: port IDs, arbiter states and the
// registered SRAM command word.
package sram_arb_pkg;

  // The command struct is sized to these widths; arbiter DW/AW must match them.
  localparam int ARB_DW = 8;
  localparam int ARB_AW = 10;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic              wr;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] din;
  } sram_cmd_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
    return (val >= lim) ? lim : val + 4'd1;
  endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Address sweep for the post-reset RAM clear: walks 0 .. 2^AW-1 while enabled,
// then raises done and holds until the next reset.
module sram_clear_seq #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          srst_i,
  input  logic          en_i,
  output logic [AW-1:0] addr_o,
  output logic          done_o
);

  logic [AW-1:0] addr_q;
  logic          done_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      addr_q <= '0;
      done_q <= 1'b0;
    end else if (en_i && !done_q) begin
      if (addr_q == {AW{1'b1}}) begin
        done_q <= 1'b1;
      end else begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  assign addr_o = addr_q;
  assign done_o = done_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter (A = video, priority; B = CPU, starvation-protected) in
// front of a posedge single-port SRAM. Optional post-reset clear: SRAM_ARB_CLEAR_EN.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int             DW         = ARB_DW,
  parameter int             AW         = ARB_AW,
  parameter int             STARVE_MAX = 3,
  parameter logic [DW-1:0]  CLEAR_VAL  = '0
) (
  input  logic          i_MCLK,
  input  logic          i_RST,

  input  logic          i_A_REQ,
  input  logic          i_A_WR,
  input  logic [AW-1:0] i_A_ADDR,
  input  logic [DW-1:0] i_A_DIN,
  output logic          o_A_ACK,
  output logic          o_A_RVALID,

  input  logic          i_B_REQ,
  input  logic          i_B_WR,
  input  logic [AW-1:0] i_B_ADDR,
  input  logic [DW-1:0] i_B_DIN,
  output logic          o_B_ACK,
  output logic          o_B_RVALID,

  output logic [DW-1:0] o_RDATA,
  output logic          o_READY,

  output logic [AW-1:0] o_SRAM_ADDR,
  output logic [DW-1:0] o_SRAM_DIN,
  output logic          o_SRAM_CS_n,
  output logic          o_SRAM_RD_n,
  output logic          o_SRAM_WR_n,
  input  logic [DW-1:0] i_SRAM_DOUT
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t    state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  sram_cmd_t     cmd_q, cmd_d;
  logic          cs_n_q;
  logic [1:0]    ack_q, ack_d;
  logic          tag1_vld_q, tag2_vld_q;
  port_id_t      tag1_port_q, tag2_port_q;
  logic          run, a_win, b_win, clr_issue, issue, rd_issue;
  logic [AW-1:0] clr_addr;
  logic          clr_done;
  logic [1:0]    rvalid;

`ifdef SRAM_ARB_CLEAR_EN
  localparam arb_state_t RST_STATE = ST_CLEAR;

  sram_clear_seq #(
    .AW(AW)
  ) u_clear_seq (
    .clk_i  (i_MCLK),
    .srst_i (i_RST),
    .en_i   (state_q == ST_CLEAR),
    .addr_o (clr_addr),
    .done_o (clr_done)
  );
`else
  localparam arb_state_t RST_STATE = ST_RUN;

  assign clr_addr = '0;
  assign clr_done = 1'b1;
`endif

  always_comb begin
    run       = (state_q == ST_RUN);
    clr_issue = (state_q == ST_CLEAR) && !clr_done;
    // A keeps priority until B has been passed over STARVE_MAX times in a row.
    a_win     = run && i_A_REQ && (!i_B_REQ || (starve_q != STARVE_LIM));
    b_win     = run && i_B_REQ && !a_win;
    issue     = a_win || b_win || clr_issue;
    rd_issue  = (a_win && !i_A_WR) || (b_win && !i_B_WR);

    cmd_d = cmd_q;
    if (clr_issue) begin
      cmd_d = '{wr: 1'b1, addr: clr_addr, din: CLEAR_VAL};
    end else if (a_win) begin
      cmd_d = '{wr: i_A_WR, addr: i_A_ADDR, din: i_A_DIN};
    end else if (b_win) begin
      cmd_d = '{wr: i_B_WR, addr: i_B_ADDR, din: i_B_DIN};
    end

    ack_d    = {b_win, a_win};
    starve_d = (a_win && i_B_REQ) ? sat_inc(starve_q, STARVE_LIM) : 4'd0;

    state_d = state_q;
    if ((state_q == ST_CLEAR) && clr_done) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state_q     <= RST_STATE;
      starve_q    <= 4'd0;
      cmd_q       <= '0;
      cs_n_q      <= 1'b1;
      ack_q       <= 2'b00;
      tag1_vld_q  <= 1'b0;
      tag2_vld_q  <= 1'b0;
      tag1_port_q <= PORT_A;
      tag2_port_q <= PORT_A;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      cmd_q       <= cmd_d;
      cs_n_q      <= !issue;
      ack_q       <= ack_d;
      tag1_vld_q  <= rd_issue;
      tag1_port_q <= b_win ? PORT_B : PORT_A;
      tag2_vld_q  <= tag1_vld_q;
      tag2_port_q <= tag1_port_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign rvalid[gi] = tag2_vld_q && (tag2_port_q == ((gi == 0) ? PORT_A : PORT_B));
    end
  endgenerate

  // Strobes are decoded from the registered chip select so they only toggle at the edge.
  assign o_SRAM_CS_n = cs_n_q;
  assign o_SRAM_RD_n = cs_n_q || cmd_q.wr;
  assign o_SRAM_WR_n = cs_n_q || !cmd_q.wr;
  assign o_SRAM_ADDR = cmd_q.addr;
  assign o_SRAM_DIN  = cmd_q.din;

  assign o_A_ACK    = ack_q[0];
  assign o_B_ACK    = ack_q[1];
  assign o_A_RVALID = rvalid[0];
  assign o_B_RVALID = rvalid[1];
  assign o_RDATA    = i_SRAM_DOUT;
  assign o_READY    = (state_q == ST_RUN);

endmodule
